// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues single-outstanding instruction memory
// requests for pc_i, pairs each returned word with its PC and buffers the
// pairs in a circular queue for decode. Stale fetches are dropped on flush.
// Optional feature macro: FETCH_BYPASS_EN (empty-queue responses go straight
// to decode in the same cycle they return).

package mmm_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

module fetch_stage
  import mmm_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            fetch_ready_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            dec_ready_i
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [XLEN-1:0]  req_pc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ILEN-1:0]  q_instr [QUEUE_DEPTH];
  logic [XLEN-1:0]  q_pc    [QUEUE_DEPTH];

  logic push;    // a live response returns this cycle
  logic q_push;  // that response is written into the queue storage
  logic q_pop;   // the queue head is consumed by decode

  // Requests only from IDLE, never on flush, and only with a free slot.
  assign imem_req_o    = (state == S_IDLE) && !flush_i && (count < CNT_W'(QUEUE_DEPTH));
  assign imem_addr_o   = pc_i;
  assign fetch_ready_o = (imem_req_o & imem_gnt_i) | flush_i;
  assign push          = (state == S_WAIT) && imem_rvalid_i && !flush_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  // An empty queue forwards the returning word directly to decode.
  assign bypass        = push && (count == '0);
  assign instr_valid_o = (count != '0) || bypass;
  assign instr_o       = bypass ? imem_rdata_i : q_instr[rd_ptr];
  assign instr_pc_o    = bypass ? req_pc       : q_pc[rd_ptr];
  assign q_pop         = (count != '0) && dec_ready_i;
  assign q_push        = push && !(bypass && dec_ready_i);
`else
  assign instr_valid_o = (count != '0);
  assign instr_o       = q_instr[rd_ptr];
  assign instr_pc_o    = q_pc[rd_ptr];
  assign q_pop         = instr_valid_o && dec_ready_i;
  assign q_push        = push;
`endif

  // Next-state logic for the single-outstanding request tracker.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE:    if (imem_req_o && imem_gnt_i) state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid_i)  state_nxt = S_IDLE;
        else if (flush_i)   state_nxt = S_DISCARD;
      end
      S_DISCARD: if (imem_rvalid_i) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Capture the PC of the request the memory just accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                       req_pc <= '0;
    else if (imem_req_o && imem_gnt_i) req_pc <= pc_i;
  end

  // Queue pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (q_push) wr_ptr <= wr_ptr + 1'b1;
      if (q_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({q_push, q_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage writes.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
    if (q_push) begin
      q_instr[wr_ptr] <= imem_rdata_i;
      q_pc[wr_ptr]    <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage. The bench plays both PC
// generation and instruction memory; expected decode traffic is pushed into
// a queue when a live response is returned and popped by an independent
// monitor whenever decode accepts an instruction.

module tb_fetch_stage;
  import mmm_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            flush_i;
  logic [XLEN-1:0] pc_i;
  logic            fetch_ready_o;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;
  logic            instr_valid_o;
  logic [ILEN-1:0] instr_o;
  logic [XLEN-1:0] instr_pc_o;
  logic            dec_ready_i;

  fetch_stage #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .flush_i       (flush_i),
    .pc_i          (pc_i),
    .fetch_ready_o (fetch_ready_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .dec_ready_i   (dec_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    int              cyc;
  } entry_t;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  bit     running  = 1'b0;

  // Memory / PC-generation model state.
  bit              outstanding, stale, prev_flush, prev_grant;
  int              lat;
  logic [XLEN-1:0] out_pc, flush_target;
  int              ready_pct, gnt_pct, flush_pct;
  bit              exp_req, exp_fr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: decode-side visibility and in-order delivery against the scoreboard.
  always @(negedge clk_i) begin
    if (running && rst_n_i) begin
      automatic bit vis = (exp_q.size() > 0) && (BYPASS || exp_q[0].cyc < cyc);
      check("instr_valid", {31'b0, instr_valid_o}, {31'b0, vis});
      if (instr_valid_o && dec_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          check("spurious_instr", {31'b0, instr_valid_o}, 32'd0);
        end else begin
          automatic entry_t e = exp_q.pop_front();
          check("instr", instr_o, e.instr);
          check("instr_pc", instr_pc_o, e.pc);
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    outstanding = 1'b0;
    stale       = 1'b0;
    prev_flush  = 1'b0;
    prev_grant  = 1'b0;
  endtask

  // One clock cycle of PC generation + memory behaviour, then protocol checks.
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    // Consequences of the previous cycle.
    if (prev_flush) begin
      exp_q.delete();
      pc_i = flush_target;
    end else if (prev_grant) begin
      pc_i = pc_i + 32'd4;
    end
    // New stimulus.
    flush_i     = ($urandom_range(0, 99) < flush_pct);
    imem_gnt_i  = ($urandom_range(0, 99) < gnt_pct);
    dec_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (flush_i) flush_target = 32'($urandom_range(0, 16'hFFFF)) << 2;
    imem_rdata_i  = $urandom;
    imem_rvalid_i = 1'b0;
    if (outstanding) begin
      lat--;
      if (lat == 0) imem_rvalid_i = 1'b1;
    end
    // Expected fetch-side behaviour.
    exp_req = !outstanding && !flush_i && (exp_q.size() < DEPTH);
    exp_fr  = (exp_req && imem_gnt_i) || flush_i;
    if (imem_rvalid_i) begin
      if (!stale && !flush_i) exp_q.push_back('{pc: out_pc, instr: imem_rdata_i, cyc: cyc});
      outstanding = 1'b0;
    end else if (outstanding && flush_i) begin
      stale = 1'b1;
    end
    if (exp_req && imem_gnt_i) begin
      outstanding = 1'b1;
      stale       = 1'b0;
      out_pc      = pc_i;
      lat         = $urandom_range(1, 3);
    end
    prev_flush = flush_i;
    prev_grant = exp_req && imem_gnt_i;
    @(negedge clk_i);
    check("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
    check("fetch_ready", {31'b0, fetch_ready_o}, {31'b0, exp_fr});
    if (exp_req) check("imem_addr", imem_addr_o, pc_i);
  endtask

  task automatic do_reset();
    rst_n_i       = 1'b0;
    running       = 1'b0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    dec_ready_i   = 1'b0;
    pc_i          = 32'h1000;
    clear_model();
    #2;
    check("reset_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("reset_req", {31'b0, imem_req_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    running = 1'b1;
  endtask

  initial begin
    int ph_ready[4] = '{100, 0, 50, 80};
    int ph_gnt[4]   = '{100, 60, 50, 70};
    int ph_flush[4] = '{0, 0, 5, 10};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      ready_pct = ph_ready[p];
      gnt_pct   = ph_gnt[p];
      flush_pct = ph_flush[p];
      if (p == 2) begin
        // Mid-operation reset while the queue is full and traffic is live.
        @(posedge clk_i);
        #1;
        do_reset();
      end
      for (int c = 0; c < 400; c++) step();
      if (p == 1) begin
        // Queue full phase: decode never accepted, so four entries remain.
        check("full_occupancy", exp_q.size(), DEPTH);
      end
    end
    // Drain: no new grants, decode always ready, outstanding response still returns.
    gnt_pct   = 0;
    flush_pct = 0;
    ready_pct = 100;
    for (int c = 0; c < 12; c++) step();
    check("drain_empty", exp_q.size(), 0);
    check("drain_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
